ad7606_frame_fifo: RTL and testbench

- Downstream of the AD7606 8-channel sampler.
- Captures one complete 8-channel frame per conversion strobe into a circular frame buffer.
- Replays each frame as a stream of 16-bit words over a valid/ready interface, with channel index and frame-start/end flags.
- Decouples the fixed ADC conversion rate from a back-pressured consumer (UART/FFT/DMA); counts dropped frames.

---
 rtl/ad7606_frame_fifo.sv | 161 ++++++++++++++++
 tb/tb_ad7606_frame_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ad7606_frame_fifo.sv
// Circular buffer of complete AD7606 frames, replayed one word per beat over valid/ready.
// The output stage holds one frame in a shadow register, outside the stored level.
module ad7606_frame_fifo #(
  parameter int DW    = 16,
  parameter int NCH   = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_valid,
  input  logic [DW*NCH-1:0] ch_data,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DW-1:0]     m_data,
  output logic [2:0]        m_chan,
  output logic              m_sof,
  output logic              m_eof,
  output logic [AW:0]       level,
  output logic              overflow,
  output logic [15:0]       drop_cnt
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_t;

  logic [DW*NCH-1:0] r_mem [DEPTH];
  logic [DW*NCH-1:0] r_shadow;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  state_t            r_state;
  logic [2:0]        r_idx;
  logic              r_m_valid;
  logic [DW-1:0]     r_m_data;
  logic [2:0]        r_m_chan;
  logic              r_m_sof;
  logic              r_m_eof;
  logic              r_overflow;
  logic [15:0]       r_drop_cnt;

  logic              w_full;
  logic              w_hs;
  logic              w_last;
  logic              w_wr;
  logic              w_drop;
  logic              w_load;
  logic [2:0]        w_idx_inc;
  logic [DW*NCH-1:0] w_rd_word;

  assign w_full    = (r_level == (AW+1)'(DEPTH));
  assign w_hs      = r_m_valid && m_ready;
  assign w_last    = (r_idx == 3'(NCH-1));
  assign w_wr      = frame_valid && !w_full;
  assign w_drop    = frame_valid && w_full;
  assign w_idx_inc = r_idx + 3'd1;
  assign w_rd_word = r_mem[r_rd_ptr];

  // A new frame enters the output stage from IDLE, or straight after the last word (no bubble).
  always_comb begin
    w_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_level != '0) w_load = 1'b1;
        else               w_load = 1'b0;
      end
      ST_STREAM: begin
        if (w_hs && w_last && (r_level != '0)) w_load = 1'b1;
        else                                   w_load = 1'b0;
      end
      default: w_load = 1'b0;
    endcase
  end

  // Frame storage kept reset-free so it maps onto a simple dual-port RAM.
  always_ff @(posedge clk) begin
    if (w_wr && !rst && !flush) r_mem[r_wr_ptr] <= ch_data;
  end

  // Pointers, level, read FSM, registered stream outputs and drop statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_state    <= ST_IDLE;
      r_idx      <= 3'd0;
      r_shadow   <= '0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_chan   <= 3'd0;
      r_m_sof    <= 1'b0;
      r_m_eof    <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= 16'd0;
    end else if (flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_state   <= ST_IDLE;
      r_idx     <= 3'd0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_chan  <= 3'd0;
      r_m_sof   <= 1'b0;
      r_m_eof   <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);

      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end

      // Full is judged on the pre-edge level, so a same-cycle load never frees a slot for the write.
      case ({w_wr, w_load})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase

      if (w_load) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_shadow  <= w_rd_word;
        r_idx     <= 3'd0;
        r_state   <= ST_STREAM;
        r_m_valid <= 1'b1;
        r_m_data  <= w_rd_word[DW-1:0];
        r_m_chan  <= 3'd0;
        r_m_sof   <= 1'b1;
        r_m_eof   <= (NCH == 1);
      end else if ((r_state == ST_STREAM) && w_hs) begin
        if (!w_last) begin
          r_idx    <= w_idx_inc;
          r_m_data <= r_shadow[int'(w_idx_inc)*DW +: DW];
          r_m_chan <= w_idx_inc;
          r_m_sof  <= 1'b0;
          r_m_eof  <= (w_idx_inc == 3'(NCH-1));
        end else begin
          r_state   <= ST_IDLE;
          r_idx     <= 3'd0;
          r_m_valid <= 1'b0;
          r_m_data  <= '0;
          r_m_chan  <= 3'd0;
          r_m_sof   <= 1'b0;
          r_m_eof   <= 1'b0;
        end
      end
    end
  end

  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign m_chan   = r_m_chan;
  assign m_sof    = r_m_sof;
  assign m_eof    = r_m_eof;
  assign level    = r_level;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_ad7606_frame_fifo.sv
// Directed bench for ad7606_frame_fifo: latency, stalls, overflow/wrap, flush and reset.
module tb_ad7606_frame_fifo;

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_valid;
  logic [127:0] ch_data;
  logic         flush;
  logic         m_valid;
  logic         m_ready;
  logic [15:0]  m_data;
  logic [2:0]   m_chan;
  logic         m_sof;
  logic         m_eof;
  logic [4:0]   level;
  logic         overflow;
  logic [15:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;

  ad7606_frame_fifo #(.DW(16), .NCH(8), .DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .ch_data(ch_data), .flush(flush),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_chan(m_chan),
    .m_sof(m_sof), .m_eof(m_eof), .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] fdata(input int k, input int c);
    return 16'(k * 256 + c + 1);
  endfunction

  function automatic logic [127:0] pack(input int k);
    logic [127:0] p;
    for (int c = 0; c < 8; c++) p[c*16 +: 16] = fdata(k, c);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame(input int k);
    ch_data     = pack(k);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  // Receives frame k, checking every word; tog_mode toggles m_ready each cycle.
  task automatic recv_frame(input int k, input bit tog_mode, output int cyc);
    int idx;
    bit tog;
    idx = 0;
    cyc = 0;
    tog = 1'b1;
    while (idx < 8 && cyc < 200) begin
      m_ready = tog_mode ? tog : 1'b1;
      tog = ~tog;
      if (m_valid) begin
        chk("data", m_data, fdata(k, idx));
        chk("chan", m_chan, idx);
        chk("sof", m_sof, idx == 0);
        chk("eof", m_eof, idx == 7);
        if (m_ready) idx++;
      end
      tick();
      cyc++;
    end
    chk("recv_done", idx, 8);
  endtask

  initial begin
    int c;
    int total;
    int w;
    rst = 1'b1; frame_valid = 1'b0; ch_data = '0; flush = 1'b0; m_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    tick();

    // Single frame latency and content
    m_ready = 1'b1;
    pulse_frame(0);
    chk("lat_t1_valid", m_valid, 0);
    chk("lat_t1_level", level, 1);
    tick();
    chk("lat_t2_valid", m_valid, 1);
    chk("lat_t2_level", level, 0);
    recv_frame(0, 1'b0, c);
    chk("single_cycles", c, 8);
    chk("single_end_valid", m_valid, 0);
    chk("single_end_level", level, 0);

    // Three spaced frames with m_ready toggling
    for (int f = 0; f < 3; f++) begin
      pulse_frame(5 + f);
      recv_frame(5 + f, 1'b1, c);
      repeat (250 - c - 1) tick();
    end
    chk("toggle_level", level, 0);
    chk("toggle_valid", m_valid, 0);

    // Overflow: 18 frames into a stalled consumer
    m_ready = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      pulse_frame(k);
      tick();
    end
    chk("ovf_level", level, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_cnt, 1);
    chk("ovf_valid", m_valid, 1);
    chk("ovf_head", m_data, fdata(1, 0));

    // Drop on last-word handshake while full, then back-to-back drain
    m_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("f1_chan", m_chan, i);
      chk("f1_data", m_data, fdata(1, i));
      tick();
    end
    chk("f1_last_chan", m_chan, 7);
    chk("f1_last_eof", m_eof, 1);
    ch_data = pack(99);
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    chk("b2b_drop", drop_cnt, 2);
    chk("b2b_valid", m_valid, 1);
    chk("b2b_chan", m_chan, 0);
    chk("b2b_sof", m_sof, 1);
    chk("b2b_data", m_data, fdata(2, 0));
    chk("b2b_level", level, 15);
    total = 0;
    for (int k = 2; k <= 17; k++) begin
      recv_frame(k, 1'b0, c);
      total += c;
    end
    chk("drain_cycles", total, 128);
    chk("drain_valid", m_valid, 0);
    chk("drain_level", level, 0);

    // Flush mid-frame with a coincident frame_valid
    pulse_frame(20);
    w = 0;
    while (!m_valid && w < 10) begin
      tick();
      w++;
    end
    chk("flush_start", m_valid, 1);
    repeat (4) tick();
    chk("flush_pre_chan", m_chan, 4);
    chk("flush_pre_data", m_data, fdata(20, 4));
    flush = 1'b1;
    ch_data = pack(21);
    frame_valid = 1'b1;
    tick();
    flush = 1'b0;
    frame_valid = 1'b0;
    chk("flush_valid", m_valid, 0);
    chk("flush_level", level, 0);
    chk("flush_drop", drop_cnt, 2);
    chk("flush_ovf", overflow, 1);
    repeat (3) tick();
    chk("flush_discard_valid", m_valid, 0);
    chk("flush_discard_level", level, 0);
    pulse_frame(22);
    recv_frame(22, 1'b0, c);

    // Reset mid-stream with drop_cnt=5
    m_ready = 1'b0;
    for (int k = 30; k < 50; k++) begin
      pulse_frame(k);
      tick();
    end
    chk("pre_rst_drop", drop_cnt, 5);
    chk("pre_rst_level", level, 16);
    m_ready = 1'b1;
    repeat (3) tick();
    chk("pre_rst_chan", m_chan, 3);
    chk("pre_rst_data", m_data, fdata(30, 3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_valid", m_valid, 0);
    chk("rst2_data", m_data, 0);
    chk("rst2_chan", m_chan, 0);
    chk("rst2_sof", m_sof, 0);
    chk("rst2_eof", m_eof, 0);
    chk("rst2_level", level, 0);
    chk("rst2_ovf", overflow, 0);
    chk("rst2_drop", drop_cnt, 0);
    tick();
    chk("rst2_idle", m_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
